// File: rtl/ddr_user_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ddr_user_adapter
// Description : Client-side adapter onto the DDR3 controller app_* interface.
//               Registers commands and write beats until the controller takes
//               them, frames write bursts, bounds write-data lead and buffers
//               read data in a credit-reserved FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr_user_adapter #(
    parameter int ADDR_WIDTH  = 27,
    parameter int DATA_WIDTH  = 256,
    parameter int MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int BEATS       = 2,
    parameter int RD_DEPTH    = 8,
    parameter int MAX_WR_LEAD = 2
) (
    input  logic                        user_clock,
    input  logic                        user_reset,
    input  logic                        init_done,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_WIDTH-1:0]       req_addr,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [MASK_WIDTH-1:0]       wr_mask,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        app_en,
    output logic [2:0]                  app_cmd,
    output logic [ADDR_WIDTH-1:0]       app_addr,
    input  logic                        app_rdy,
    output logic                        app_wdf_wren,
    output logic [DATA_WIDTH-1:0]       app_wdf_data,
    output logic [MASK_WIDTH-1:0]       app_wdf_mask,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]       app_rd_data,
    input  logic                        app_rd_data_valid,
    output logic [$clog2(RD_DEPTH):0]   rd_reserved,
    output logic                        err_unexpected_rd
);

    localparam int c_CNT_W  = $clog2(RD_DEPTH) + 1;
    localparam int c_PTR_W  = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam int c_BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_LEAD_W = $clog2(MAX_WR_LEAD + 1) + 2;
    localparam int c_SUM_W  = c_CNT_W + 2;

    localparam logic signed [c_LEAD_W-1:0] c_LEAD_MAX = c_LEAD_W'(MAX_WR_LEAD);
    localparam logic signed [c_LEAD_W-1:0] c_LEAD_MIN = -c_LEAD_MAX;
    localparam logic signed [c_LEAD_W-1:0] c_LEAD_ONE = c_LEAD_W'(1);
    localparam logic [2:0]                 c_CMD_WRITE = 3'b000;
    localparam logic [2:0]                 c_CMD_READ  = 3'b001;
    localparam logic [c_BEAT_W-1:0]        c_LAST_BEAT = c_BEAT_W'(BEATS - 1);
    localparam logic [c_PTR_W-1:0]         c_PTR_LAST  = c_PTR_W'(RD_DEPTH - 1);

    // Registered state
    logic                         r_app_en;
    logic [2:0]                   r_app_cmd;
    logic [ADDR_WIDTH-1:0]        r_app_addr;
    logic                         r_wdf_wren;
    logic [DATA_WIDTH-1:0]        r_wdf_data;
    logic [MASK_WIDTH-1:0]        r_wdf_mask;
    logic                         r_wdf_end;
    logic [c_BEAT_W-1:0]          r_beat_cnt;
    logic signed [c_LEAD_W-1:0]   r_wr_lead;
    logic [c_CNT_W-1:0]           r_rd_reserved;
    logic                         r_err;
    logic [DATA_WIDTH-1:0]        r_fifo_mem [RD_DEPTH];
    logic [c_PTR_W-1:0]           r_wr_ptr;
    logic [c_PTR_W-1:0]           r_rd_ptr;
    logic [c_CNT_W-1:0]           r_fifo_count;

    // Combinational handshakes
    logic                         w_cmd_slot_free;
    logic                         w_wdf_slot_free;
    logic [c_SUM_W-1:0]           w_credit_sum;
    logic                         w_rd_credit_ok;
    logic                         w_wr_lead_ok;
    logic                         w_req_fire;
    logic                         w_rd_accept;
    logic                         w_wr_cmd_accept;
    logic                         w_wr_fire;
    logic                         w_last_beat;
    logic                         w_burst_done;
    logic                         w_rd_unexpected;
    logic                         w_rd_push;
    logic                         w_rd_pop;

    assign w_cmd_slot_free = !r_app_en || app_rdy;
    assign w_wdf_slot_free = !r_wdf_wren || app_wdf_rdy;

    // A read may only be taken if its whole burst is guaranteed FIFO space,
    // counting both beats still in flight and beats already buffered.
    assign w_credit_sum   = c_SUM_W'(r_rd_reserved) + c_SUM_W'(r_fifo_count) + c_SUM_W'(BEATS);
    assign w_rd_credit_ok = w_credit_sum <= c_SUM_W'(RD_DEPTH);
    assign w_wr_lead_ok   = r_wr_lead > c_LEAD_MIN;

    assign req_ready = !user_reset && init_done && w_cmd_slot_free &&
                       (req_write ? w_wr_lead_ok : w_rd_credit_ok);
    assign w_req_fire      = req_valid && req_ready;
    assign w_rd_accept     = w_req_fire && !req_write;
    assign w_wr_cmd_accept = w_req_fire && req_write;

    // New bursts are held off at the lead limit; a burst in progress finishes.
    assign w_last_beat  = r_beat_cnt == c_LAST_BEAT;
    assign wr_ready     = !user_reset && init_done && w_wdf_slot_free &&
                          !((r_beat_cnt == '0) && (r_wr_lead == c_LEAD_MAX));
    assign w_wr_fire    = wr_valid && wr_ready;
    assign w_burst_done = w_wr_fire && w_last_beat;

    assign w_rd_unexpected = app_rd_data_valid && (r_rd_reserved == '0);
    assign w_rd_push       = app_rd_data_valid && !w_rd_unexpected;
    assign rsp_valid       = r_fifo_count != '0;
    assign w_rd_pop        = rsp_valid && rsp_ready;
    assign rsp_data        = rsp_valid ? r_fifo_mem[r_rd_ptr] : '0;

    assign app_en            = r_app_en;
    assign app_cmd           = r_app_cmd;
    assign app_addr          = r_app_addr;
    assign app_wdf_wren      = r_wdf_wren;
    assign app_wdf_data      = r_wdf_data;
    assign app_wdf_mask      = r_wdf_mask;
    assign app_wdf_end       = r_wdf_end;
    assign rd_reserved       = r_rd_reserved;
    assign err_unexpected_rd = r_err;

    // Command register: load on accept, hold until the controller takes it.
    always_ff @(posedge user_clock) begin
        if (user_reset) begin
            r_app_en   <= 1'b0;
            r_app_cmd  <= '0;
            r_app_addr <= '0;
        end else if (w_req_fire) begin
            r_app_en   <= 1'b1;
            r_app_cmd  <= req_write ? c_CMD_WRITE : c_CMD_READ;
            r_app_addr <= req_addr;
        end else if (app_rdy) begin
            r_app_en   <= 1'b0;
        end
    end

    // Write-data register with burst framing from the beat counter.
    always_ff @(posedge user_clock) begin
        if (user_reset) begin
            r_wdf_wren <= 1'b0;
            r_wdf_data <= '0;
            r_wdf_mask <= '0;
            r_wdf_end  <= 1'b0;
            r_beat_cnt <= '0;
        end else if (w_wr_fire) begin
            r_wdf_wren <= 1'b1;
            r_wdf_data <= wr_data;
            r_wdf_mask <= wr_mask;
            r_wdf_end  <= w_last_beat;
            r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + c_BEAT_W'(1);
        end else if (app_wdf_rdy) begin
            r_wdf_wren <= 1'b0;
        end
    end

    // Signed balance of completed data bursts against accepted write commands.
    always_ff @(posedge user_clock) begin
        if (user_reset) begin
            r_wr_lead <= '0;
        end else if (w_burst_done && !w_wr_cmd_accept) begin
            r_wr_lead <= r_wr_lead + c_LEAD_ONE;
        end else if (!w_burst_done && w_wr_cmd_accept) begin
            r_wr_lead <= r_wr_lead - c_LEAD_ONE;
        end
    end

    // Read-beat reservations and the sticky unexpected-beat flag.
    always_ff @(posedge user_clock) begin
        if (user_reset) begin
            r_rd_reserved <= '0;
            r_err         <= 1'b0;
        end else begin
            r_rd_reserved <= r_rd_reserved
                           + (w_rd_accept ? c_CNT_W'(BEATS) : '0)
                           - (w_rd_push   ? c_CNT_W'(1)     : '0);
            if (w_rd_unexpected) begin
                r_err <= 1'b1;
            end
        end
    end

    // Read FIFO storage; pointers make stale contents unreachable after reset.
    always_ff @(posedge user_clock) begin
        if (w_rd_push) begin
            r_fifo_mem[r_wr_ptr] <= app_rd_data;
        end
    end

    // Read FIFO pointers and occupancy.
    always_ff @(posedge user_clock) begin
        if (user_reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_rd_push) begin
                r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            if (w_rd_push && !w_rd_pop) begin
                r_fifo_count <= r_fifo_count + c_CNT_W'(1);
            end else if (!w_rd_push && w_rd_pop) begin
                r_fifo_count <= r_fifo_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr_user_adapter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_ddr_user_adapter
// Description : Scoreboarded bench for ddr_user_adapter (BEATS=2, RD_DEPTH=8,
//               MAX_WR_LEAD=2, 32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_user_adapter;

    localparam int AW          = 27;
    localparam int DW          = 32;
    localparam int MW          = DW / 8;
    localparam int BEATS       = 2;
    localparam int RD_DEPTH    = 8;
    localparam int MAX_WR_LEAD = 2;
    localparam int RW          = $clog2(RD_DEPTH) + 1;

    logic          user_clock = 1'b0;
    logic          user_reset;
    logic          init_done;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          app_en;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic          app_rdy;
    logic          app_wdf_wren;
    logic [DW-1:0] app_wdf_data;
    logic [MW-1:0] app_wdf_mask;
    logic          app_wdf_end;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
    logic [RW-1:0] rd_reserved;
    logic          err_unexpected_rd;

    int n_tests = 0;
    int n_fail  = 0;
    int tb_beat = 0;

    // Scoreboard queues: {cmd, addr}, {data, mask, end}, read data
    logic [AW+2:0]  q_cmd [$];
    logic [DW+MW:0] q_wdf [$];
    logic [DW-1:0]  q_rsp [$];
    logic [AW+2:0]  e_cmd;
    logic [DW+MW:0] e_wdf;
    logic [DW-1:0]  e_rsp;

    always #5 user_clock = ~user_clock;

    ddr_user_adapter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MASK_WIDTH (MW),
        .BEATS      (BEATS),
        .RD_DEPTH   (RD_DEPTH),
        .MAX_WR_LEAD(MAX_WR_LEAD)
    ) dut (
        .user_clock       (user_clock),
        .user_reset       (user_reset),
        .init_done        (init_done),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_addr         (req_addr),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .wr_mask          (wr_mask),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .app_en           (app_en),
        .app_cmd          (app_cmd),
        .app_addr         (app_addr),
        .app_rdy          (app_rdy),
        .app_wdf_wren     (app_wdf_wren),
        .app_wdf_data     (app_wdf_data),
        .app_wdf_mask     (app_wdf_mask),
        .app_wdf_end      (app_wdf_end),
        .app_wdf_rdy      (app_wdf_rdy),
        .app_rd_data      (app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .rd_reserved      (rd_reserved),
        .err_unexpected_rd(err_unexpected_rd)
    );

    // Output monitor: every transfer on the three output channels pops and checks the scoreboard.
    always @(negedge user_clock) begin
        if (app_en && app_rdy) begin
            n_tests++;
            if (q_cmd.size() == 0) begin
                n_fail++;
                $display("FAIL app_cmd_unexpected: got cmd=%b addr=%h, required no command", app_cmd, app_addr);
            end else begin
                e_cmd = q_cmd.pop_front();
                if ({app_cmd, app_addr} !== e_cmd) begin
                    n_fail++;
                    $display("FAIL app_cmd: got cmd=%b addr=%h, required cmd=%b addr=%h",
                             app_cmd, app_addr, e_cmd[AW+2:AW], e_cmd[AW-1:0]);
                end
            end
        end
        if (app_wdf_wren && app_wdf_rdy) begin
            n_tests++;
            if (q_wdf.size() == 0) begin
                n_fail++;
                $display("FAIL wdf_unexpected: got data=%h, required no beat", app_wdf_data);
            end else begin
                e_wdf = q_wdf.pop_front();
                if ({app_wdf_data, app_wdf_mask, app_wdf_end} !== e_wdf) begin
                    n_fail++;
                    $display("FAIL wdf_beat: got data=%h mask=%h end=%b, required data=%h mask=%h end=%b",
                             app_wdf_data, app_wdf_mask, app_wdf_end,
                             e_wdf[DW+MW:MW+1], e_wdf[MW:1], e_wdf[0]);
                end
            end
        end
        if (rsp_valid && rsp_ready) begin
            n_tests++;
            if (q_rsp.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got data=%h, required no response", rsp_data);
            end else begin
                e_rsp = q_rsp.pop_front();
                if (rsp_data !== e_rsp) begin
                    n_fail++;
                    $display("FAIL rsp_data: got %h, required %h", rsp_data, e_rsp);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge user_clock);
        #1;
    endtask

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input int budget, output bit accepted);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        accepted  = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge user_clock);
            if (req_ready) begin
                accepted = 1'b1;
                q_cmd.push_back({(wr ? 3'b000 : 3'b001), addr});
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [MW-1:0] m, input int budget, output bit accepted);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_mask  = m;
        accepted = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge user_clock);
            if (wr_ready) begin
                accepted = 1'b1;
                q_wdf.push_back({d, m, (tb_beat == BEATS - 1)});
                tb_beat = (tb_beat + 1) % BEATS;
            end
            step();
        end
        wr_valid = 1'b0;
    endtask

    task automatic rd_return(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = base + DW'(i);
            q_rsp.push_back(base + DW'(i));
            step();
        end
        app_rd_data_valid = 1'b0;
        app_rd_data       = '0;
    endtask

    task automatic test_reset();
        user_reset = 1'b1;
        init_done  = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        wr_valid   = 1'b1;
        step(); step(); step();
        @(negedge user_clock);
        n_tests++;
        if ({req_ready, wr_ready, app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_data, app_wdf_mask,
             app_wdf_end, rsp_valid, rsp_data, rd_reserved, err_unexpected_rd} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req_ready=%b wr_ready=%b app_en=%b wren=%b rsp_valid=%b rd_reserved=%0d err=%b, required all 0",
                     req_ready, wr_ready, app_en, app_wdf_wren, rsp_valid, rd_reserved, err_unexpected_rd);
        end
        step();
        req_valid = 1'b0;
        wr_valid  = 1'b0;
        init_done = 1'b0;
        step();
        user_reset = 1'b0;
        step();
    endtask

    task automatic test_init_gate();
        int bad = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 27'h40;
        for (int i = 0; i < 50; i++) begin
            @(negedge user_clock);
            if (req_ready !== 1'b0 || app_en !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL init_gate: got %0d cycles with req_ready/app_en high, required 0", bad);
        end
        init_done = 1'b1;
        @(negedge user_clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL init_rise_ready: got req_ready=%b, required 1", req_ready);
        end else begin
            q_cmd.push_back({3'b001, 27'h40});
        end
        step();
        req_valid = 1'b0;
        @(negedge user_clock);
        n_tests++;
        if (app_en !== 1'b1) begin
            n_fail++;
            $display("FAIL init_rise_app_en: got app_en=%b, required 1", app_en);
        end
        step();
        rd_return(2, 32'h0000_1000);
        step(); step(); step();
        @(negedge user_clock);
        n_tests++;
        if (rsp_valid !== 1'b0 || rd_reserved !== RW'(0)) begin
            n_fail++;
            $display("FAIL init_read_drain: got rsp_valid=%b rd_reserved=%0d, required 0 and 0", rsp_valid, rd_reserved);
        end
        step();
    endtask

    task automatic test_write_hold();
        bit acc;
        app_rdy = 1'b0;
        send_cmd(1'b1, 27'h100, 4, acc);
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL wcmd_accept: got accepted=%b, required 1", acc);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) app_rdy = 1'b1;
            @(negedge user_clock);
            n_tests++;
            if (app_en !== 1'b1 || app_addr !== 27'h100 || app_cmd !== 3'b000) begin
                n_fail++;
                $display("FAIL wcmd_hold[%0d]: got app_en=%b addr=%h cmd=%b, required 1 100 000", k, app_en, app_addr, app_cmd);
            end
            if (k == 0) begin
                n_tests++;
                if (req_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cmd_slot_busy: got req_ready=%b, required 0", req_ready);
                end
            end
            step();
        end
        @(negedge user_clock);
        n_tests++;
        if (app_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wcmd_release: got app_en=%b, required 0", app_en);
        end
        step();
        app_wdf_rdy = 1'b0;
        send_beat(32'hD0D0_0000, 4'h1, 4, acc);
        @(negedge user_clock);
        n_tests++;
        if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wdf_hold: got wren=%b end=%b wr_ready=%b, required 1 0 0", app_wdf_wren, app_wdf_end, wr_ready);
        end
        step();
        app_wdf_rdy = 1'b1;
        send_beat(32'hD1D1_1111, 4'h8, 4, acc);
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL wdf_second_beat: got accepted=%b, required 1", acc);
        end
        step(); step();
    endtask

    task automatic test_rd_credit();
        bit acc;
        rsp_ready = 1'b0;
        app_rdy   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_cmd(1'b0, AW'(32'h200 + 2 * i), 3, acc);
            n_tests++;
            if (acc !== (i < 4)) begin
                n_fail++;
                $display("FAIL rd_credit_accept[%0d]: got accepted=%b, required %b", i, acc, (i < 4));
            end
        end
        @(negedge user_clock);
        n_tests++;
        if (rd_reserved !== RW'(8)) begin
            n_fail++;
            $display("FAIL rd_reserved_full: got %0d, required 8", rd_reserved);
        end
        step();
        rd_return(8, 32'h0000_B000);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 27'h208;
        @(negedge user_clock);
        n_tests++;
        if (rd_reserved !== RW'(0) || rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fifo_full_state: got rd_reserved=%0d rsp_valid=%b req_ready=%b, required 0 1 0",
                     rd_reserved, rsp_valid, req_ready);
        end
        step();
        rsp_ready = 1'b1;
        step();
        @(negedge user_clock);
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_one_pop: got req_ready=%b, required 0", req_ready);
        end
        step();
        rsp_ready = 1'b0;
        @(negedge user_clock);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_two_pops: got req_ready=%b, required 1", req_ready);
        end else begin
            q_cmd.push_back({3'b001, 27'h208});
        end
        step();
        req_valid = 1'b0;
        rd_return(2, 32'h0000_B008);
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        @(negedge user_clock);
        n_tests++;
        if (rsp_valid !== 1'b0 || rd_reserved !== RW'(0)) begin
            n_fail++;
            $display("FAIL credit_drain: got rsp_valid=%b rd_reserved=%0d, required 0 0", rsp_valid, rd_reserved);
        end
        step();
    endtask

    task automatic test_wr_lead();
        bit acc;
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_beat(32'hE000_0000 + DW'(i), MW'(i), 3, acc);
            n_tests++;
            if (acc !== (i < 4)) begin
                n_fail++;
                $display("FAIL wr_lead_beat[%0d]: got accepted=%b, required %b", i, acc, (i < 4));
            end
        end
        @(negedge user_clock);
        n_tests++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_lead_block: got wr_ready=%b, required 0", wr_ready);
        end
        step();
        send_cmd(1'b1, 27'h400, 3, acc);
        @(negedge user_clock);
        n_tests++;
        if (acc !== 1'b1 || wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_lead_release: got accepted=%b wr_ready=%b, required 1 1", acc, wr_ready);
        end
        step();
        send_beat(32'hE000_0004, 4'h0, 3, acc);
        send_beat(32'hE000_0005, 4'hF, 3, acc);
        send_cmd(1'b1, 27'h402, 3, acc);
        send_cmd(1'b1, 27'h404, 3, acc);
        n_tests++;
        if (acc !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_lead_match_cmds: got accepted=%b, required 1", acc);
        end
        step(); step(); step();
    endtask

    task automatic test_back_to_back();
        int stalls = 0;
        int issued = 0;
        rsp_ready = 1'b1;
        app_rdy   = 1'b1;
        fork
            begin
                bit got;
                req_valid = 1'b1;
                req_write = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    req_addr = AW'(32'h600 + 2 * i);
                    got = 1'b0;
                    for (int t = 0; t < 20 && !got; t++) begin
                        @(negedge user_clock);
                        if (req_ready) begin
                            got = 1'b1;
                            q_cmd.push_back({3'b001, req_addr});
                        end
                        step();
                    end
                    if (got) issued++;
                end
                req_valid = 1'b0;
            end
            begin
                step(); step();
                for (int j = 0; j < 16; j++) begin
                    app_rd_data_valid = 1'b1;
                    app_rd_data       = 32'h0000_C000 + DW'(j);
                    q_rsp.push_back(32'h0000_C000 + DW'(j));
                    @(negedge user_clock);
                    if (j > 0 && rsp_valid !== 1'b1) stalls++;
                    step();
                end
                app_rd_data_valid = 1'b0;
                @(negedge user_clock);
                if (rsp_valid !== 1'b1) stalls++;
                step();
            end
        join
        n_tests++;
        if (issued != 8) begin
            n_fail++;
            $display("FAIL b2b_issued: got %0d reads accepted, required 8", issued);
        end
        n_tests++;
        if (stalls != 0) begin
            n_fail++;
            $display("FAIL b2b_rsp_stall: got %0d stalled cycles, required 0", stalls);
        end
        step(); step();
        @(negedge user_clock);
        n_tests++;
        if (rd_reserved !== RW'(0) || err_unexpected_rd !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final: got rd_reserved=%0d err=%b rsp_valid=%b, required 0 0 0",
                     rd_reserved, err_unexpected_rd, rsp_valid);
        end
        step();
    endtask

    task automatic test_reset_unexpected();
        bit acc;
        rsp_ready = 1'b1;
        send_cmd(1'b0, 27'h500, 4, acc);
        send_cmd(1'b0, 27'h502, 4, acc);
        step();
        @(negedge user_clock);
        n_tests++;
        if (rd_reserved !== RW'(4)) begin
            n_fail++;
            $display("FAIL pre_reset_reserved: got %0d, required 4", rd_reserved);
        end
        step();
        user_reset = 1'b1;
        tb_beat    = 0;
        step(); step();
        user_reset = 1'b0;
        @(negedge user_clock);
        n_tests++;
        if (rd_reserved !== RW'(0) || err_unexpected_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: got rd_reserved=%0d err=%b, required 0 0", rd_reserved, err_unexpected_rd);
        end
        step();
        app_rd_data_valid = 1'b1;
        app_rd_data       = 32'h0000_DEAD;
        step();
        app_rd_data_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge user_clock);
            n_tests++;
            if (err_unexpected_rd !== 1'b1 || rsp_valid !== 1'b0 || rd_reserved !== RW'(0)) begin
                n_fail++;
                $display("FAIL unexpected_rd[%0d]: got err=%b rsp_valid=%b rd_reserved=%0d, required 1 0 0",
                         k, err_unexpected_rd, rsp_valid, rd_reserved);
            end
            step();
        end
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        @(negedge user_clock);
        n_tests++;
        if (err_unexpected_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got err=%b, required 0", err_unexpected_rd);
        end
        step();
    endtask

    task automatic test_drained();
        n_tests++;
        if (q_cmd.size() != 0) begin
            n_fail++;
            $display("FAIL cmd_queue_left: got %0d pending, required 0", q_cmd.size());
        end
        n_tests++;
        if (q_wdf.size() != 0) begin
            n_fail++;
            $display("FAIL wdf_queue_left: got %0d pending, required 0", q_wdf.size());
        end
        n_tests++;
        if (q_rsp.size() != 0) begin
            n_fail++;
            $display("FAIL rsp_queue_left: got %0d pending, required 0", q_rsp.size());
        end
    endtask

    initial begin
        user_reset        = 1'b1;
        init_done         = 1'b0;
        req_valid         = 1'b0;
        req_write         = 1'b0;
        req_addr          = '0;
        wr_valid          = 1'b0;
        wr_data           = '0;
        wr_mask           = '0;
        rsp_ready         = 1'b1;
        app_rdy           = 1'b1;
        app_wdf_rdy       = 1'b1;
        app_rd_data       = '0;
        app_rd_data_valid = 1'b0;
        step();
        test_reset();
        test_init_gate();
        test_write_hold();
        test_rd_credit();
        test_wr_lead();
        test_back_to_back();
        test_reset_unexpected();
        test_drained();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_user_adapter.md
Name: ddr_user_adapter

Overview:
Parametrised client-side adapter between a BSV memory client and the DDR3 controller user interface (app_* command, write-data and read-data channels). It registers and holds commands until the controller accepts them, and frames write beats into bursts with a correct app_wdf_end. It bounds how far write data may lead its command. Because the controller read channel has no backpressure, it buffers read data in a credit-reserved FIFO, so it can never overflow.

Parameters:
ADDR_WIDTH, 27, app_addr width
DATA_WIDTH, 256, UI data width; must be a multiple of 8
MASK_WIDTH, DATA_WIDTH/8, byte-mask width
BEATS, 2, UI beats per burst; power of two, >=1
RD_DEPTH, 8, read FIFO depth in beats; power of two, >=BEATS
MAX_WR_LEAD, 2, max completed write-data bursts not yet matched by an issued write command

Ports:
user_clock  in  1  sole clock
user_reset  in  1  synchronous, active-high reset
init_done  in  1  controller calibration complete
req_valid  in  1  client command valid
req_ready  out  1  command accepted when req_valid&req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  burst address
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted when wr_valid&wr_ready
wr_data  in  DATA_WIDTH  write beat data
wr_mask  in  MASK_WIDTH  write byte mask (1=masked)
rsp_valid  out  1  read beat available
rsp_ready  in  1  read beat consumed when rsp_valid&rsp_ready
rsp_data  out  DATA_WIDTH  read beat data
app_en  out  1  controller command valid
app_cmd  out  3  000=write, 001=read
app_addr  out  ADDR_WIDTH  controller address
app_rdy  in  1  controller command ready
app_wdf_wren  out  1  write-data valid
app_wdf_data  out  DATA_WIDTH  write data
app_wdf_mask  out  MASK_WIDTH  write mask
app_wdf_end  out  1  last beat of burst
app_wdf_rdy  in  1  write-data ready
app_rd_data  in  DATA_WIDTH  read data
app_rd_data_valid  in  1  read data valid (no backpressure)
rd_reserved  out  clog2(RD_DEPTH)+1  read beats reserved but not yet returned
err_unexpected_rd  out  1  sticky: read beat arrived with rd_reserved==0

Behaviour:
- Reset: all outputs 0; command and wdf registers empty; FIFO empty; rd_reserved, wr_lead and beat counter 0; err cleared. Reset mid-operation discards everything held; no partial burst resumes.
- Command stage, one-entry register:
  - Slot free = !app_en | app_rdy.
  - req_ready = init_done & slot free & (req_write ? wr_lead_ok : rd_credit_ok).
  - Accept in cycle N -> app_en=1 with cmd/addr in cycle N+1.
  - cmd/addr are held stable until app_en&app_rdy.
  - Back-to-back accept is allowed in the cycle app_rdy fires.
- Read credit:
  - rd_credit_ok = (rd_reserved + fifo_count + BEATS) <= RD_DEPTH.
  - rd_reserved += BEATS on read accept; -= 1 per app_rd_data_valid.
  - Both events in the same cycle: net +BEATS-1.
- Write lead:
  - wr_lead (signed) +1 on each accepted last beat of a burst; -1 on each write command accept; both in the same cycle leave it unchanged.
  - wr_lead_ok = wr_lead > -MAX_WR_LEAD.
  - wr_ready = init_done & wdf slot free & !(beat_cnt==0 & wr_lead==MAX_WR_LEAD).
  - A burst already started always completes.
- Write data: one-entry register; accept in cycle N -> app_wdf_wren=1 in N+1, held until app_wdf_rdy.
- Burst framing: beat_cnt wraps modulo BEATS on each accepted beat. app_wdf_end=1 iff the registered beat had beat_cnt==BEATS-1; with BEATS=1 it is always 1.
- Read path:
  - An app_rd_data_valid beat in cycle M is pushed into the FIFO; rsp_valid=1 from M+1, in order.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
  - FIFO is full-safe by credit construction.
- Unexpected read: app_rd_data_valid with rd_reserved==0 -> beat dropped, rd_reserved stays 0, err_unexpected_rd=1 until user_reset.
- init_done low: req_ready=wr_ready=0. Already-registered command and write data stay presented. The read path keeps operating.

Test Plan:
- init_done=0, req_valid=1 for 50 cycles -> req_ready=0, app_en=0. Raise init_done -> req_ready=1 same cycle, app_en=1 next cycle.
- Write cmd addr 0x100 plus beats D0,D1 (BEATS=2); app_rdy low 3 cycles -> app_en/app_addr=0x100 held 4 cycles, app_cmd=000; wdf_wren 2 beats, app_wdf_end only on D1.
- RD_DEPTH=8, BEATS=2, rsp_ready=0, five reads offered -> four accepted, rd_reserved=8, fifth blocked. Return 8 beats -> rd_reserved=0, rsp_valid=1. Pop 2 -> fifth accepted next cycle.
- MAX_WR_LEAD=2, three data bursts with no commands -> wr_ready=0 after beat 4. One write command accepted -> wr_ready=1 next cycle.
- Reset asserted with 4 beats reserved, then 1 app_rd_data_valid beat -> beat dropped, err_unexpected_rd=1, rsp_valid stays 0.
- Continuous reads, rsp_ready=1, controller returning every cycle -> one rsp beat per cycle, data order preserved, no credit stall.
